cmp_sort_ctrl: RTL
==================

CMP_SORT_CTRL -- requirements
Module: cmp_sort_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter: DEPTH, default 8, number of bytes per sort job; legal range 2..16.
REQ-003 Ports, in order:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  input byte valid
  in_ready  out  1  block accepts input byte
  in_data  in  8  unsigned input byte
  desc  in  1  sort order, sampled with first byte of job (0 = ascending, 1 = descending)
  out_valid  out  1  output byte valid
  out_ready  in  1  sink accepts output byte
  out_data  out  8  sorted byte
  out_last  out  1  marks final byte of job
  busy  out  1  job in progress (LOAD/SORT/OUT)
  cmp_a  out  8  operand A to shared 8-bit comparator
  cmp_b  out  8  operand B to shared 8-bit comparator
  cmp_f  in  8  comparator flags: bit2 = G (A>B), bit1 = E (A==B), bit0 = L (A<B), all unsigned; bits 7:3 = 0
  cmp_err  out  1  sticky illegal-flag indicator

Function
REQ-004 The comparator SHALL be external combinational logic; the block SHALL drive cmp_a/cmp_b and sample cmp_f in the same cycle.
REQ-005 The FSM SHALL have exactly four states: IDLE, LOAD, SORT, OUT.
REQ-006 A transfer SHALL occur on any edge where valid and ready are both 1; in_ready SHALL be 1 in IDLE and LOAD only.
REQ-007 In IDLE, an input transfer SHALL store the byte at index 0, latch desc, and move the FSM to LOAD.
REQ-008 In LOAD, each transfer SHALL store the byte at the next index; the transfer of byte DEPTH-1 SHALL move the FSM to SORT.
REQ-009 SORT SHALL run a bubble sort as DEPTH-1 passes of DEPTH-1 compares each, one compare per cycle. Index i SHALL step 0..DEPTH-2 within each pass. SORT SHALL last exactly (DEPTH-1)^2 cycles (49 for DEPTH = 8).
REQ-010 In SORT, cmp_a SHALL equal mem[i] and cmp_b SHALL equal mem[i+1]. At the clock edge the two entries SHALL swap if (desc = 0 and G = 1) or (desc = 1 and L = 1). E = 1 SHALL never cause a swap.
REQ-011 After the last SORT cycle the FSM SHALL move to OUT.
REQ-012 Outside SORT, cmp_a and cmp_b SHALL be 0.
REQ-013 In OUT, out_valid SHALL be 1 and out_data SHALL be mem[k], for k = 0..DEPTH-1. out_last SHALL be 1 only when k = DEPTH-1.
REQ-014 In OUT, k SHALL advance only on an output transfer; out_data and out_last SHALL stay stable while out_ready = 0.
REQ-015 The transfer with out_last = 1 SHALL return the FSM to IDLE. A new job's first byte SHALL be accepted no earlier than the following cycle.
REQ-016 Outside OUT, out_valid, out_data and out_last SHALL be 0.
REQ-017 busy SHALL be 1 in LOAD, SORT and OUT, and 0 in IDLE.
REQ-018 In SORT, cmp_f is illegal if bits 7:3 ≠ 0 or the count of set bits among G/E/L ≠ 1. An illegal sample SHALL set cmp_err and SHALL NOT swap.
REQ-019 cmp_err SHALL hold until reset and SHALL NOT stop the sort.
REQ-020 in_valid SHALL be ignored in SORT and OUT. desc SHALL be ignored except on the first byte of a job.
REQ-021 Total job latency from the last input transfer to the first out_valid SHALL be (DEPTH-1)^2 + 1 cycles.

Reset
REQ-022 When rst = 1 at an edge, from any state (including mid-LOAD, mid-SORT or mid-OUT), the FSM SHALL go to IDLE and the partial job SHALL be discarded.
REQ-023 After reset: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0, cmp_a = 0, cmp_b = 0, cmp_err = 0, all counters = 0.
REQ-024 Storage contents need not be reset and SHALL never be visible before being rewritten by a job.

Verification
REQ-025 Ascending sort: DEPTH = 8, desc = 0, input 5,3,200,0,255,7,7,1, out_ready = 1 -> output 0,1,3,5,7,7,200,255; out_last on 255; out_valid first rises exactly 50 cycles after the last input transfer.
REQ-026 Descending sort: same input, desc = 1 -> output 255,200,7,7,5,3,1,0; toggling desc during LOAD has no effect.
REQ-027 Output backpressure: out_ready held 0 for 5 cycles at k = 3 -> out_data stays at the 4th sorted byte; no bytes are lost or duplicated; FSM returns to IDLE after the out_last transfer.
REQ-028 Reset mid-operation: rst asserted during SORT cycle 20 -> next cycle busy = 0 and in_ready = 1; a subsequent job of 8 bytes (all 0x80) outputs eight 0x80.
REQ-029 Illegal flags: cmp_f forced to 0x06 on one SORT cycle -> cmp_err = 1 from the next cycle until reset; no swap on that cycle; the job still completes.
REQ-030 Input stall: in_valid deasserted for random gaps during LOAD -> exactly DEPTH bytes are captured in order; in_ready = 0 throughout SORT and OUT.

Source files
------------

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: collects a job of DEPTH bytes, bubble-sorts them in place
// using an external shared 8-bit comparator, then streams the sorted bytes
// out under valid/ready handshaking.
module cmp_sort_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       desc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] cmp_a,
  output logic [7:0] cmp_b,
  input  logic [7:0] cmp_f,
  output logic       cmp_err
);

  // One index register serves as load pointer, compare index i and output
  // index k, since those phases never overlap.
  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_CMP = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [IW-1:0] pass_reg, pass_next;
  logic          desc_reg, desc_next;
  logic          err_reg, err_next;

  logic [7:0]    mem_reg [DEPTH];

  logic [IW-1:0] idx_inc;
  logic [7:0]    a_val;
  logic [7:0]    b_val;
  logic          flag_ok;
  logic          swap_req;
  logic          load_en;
  logic          swap_en;

  // Neighbour pair addressed by the current index, plus comparator flag decode.
  always_comb begin
    idx_inc  = idx_reg + 1'b1;
    a_val    = mem_reg[idx_reg];
    b_val    = mem_reg[idx_inc];
    // Exactly one of G/E/L may be set and the spare bits must be clear.
    flag_ok  = (cmp_f[7:3] == 5'd0) &&
               ((cmp_f[2:0] == 3'b001) || (cmp_f[2:0] == 3'b010) ||
                (cmp_f[2:0] == 3'b100));
    // Equal operands never swap, which keeps the sort stable.
    swap_req = flag_ok && (desc_reg ? cmp_f[0] : cmp_f[2]);
  end

  // State register and control counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      pass_reg  <= '0;
      desc_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      pass_reg  <= pass_next;
      desc_reg  <= desc_next;
      err_reg   <= err_next;
    end
  end

  // Next-state, counter and output decode for the four-state controller.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pass_next  = pass_reg;
    desc_next  = desc_reg;
    err_next   = err_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'd0;
    out_last   = 1'b0;
    busy       = 1'b1;
    cmp_a      = 8'd0;
    cmp_b      = 8'd0;
    load_en    = 1'b0;
    swap_en    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          // First byte of a job also fixes the sort direction.
          load_en    = 1'b1;
          desc_next  = desc;
          idx_next   = IW'(1);
          state_next = LOAD;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_en = 1'b1;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            pass_next  = '0;
            state_next = SORT;
          end else begin
            idx_next = idx_inc;
          end
        end
      end

      SORT: begin
        cmp_a   = a_val;
        cmp_b   = b_val;
        // A bad flag sample is recorded but the pass keeps running.
        if (!flag_ok) begin
          err_next = 1'b1;
        end
        swap_en = swap_req;
        if (idx_reg == LAST_CMP) begin
          idx_next = '0;
          if (pass_reg == LAST_CMP) begin
            pass_next  = '0;
            state_next = OUT;
          end else begin
            pass_next = pass_reg + 1'b1;
          end
        end else begin
          idx_next = idx_inc;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        out_data  = a_val;
        out_last  = (idx_reg == LAST_IDX);
        if (out_ready) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx_inc;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job storage: written by input transfers, or as a swapped pair during SORT.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_reg[idx_reg] <= in_data;
    end else if (swap_en) begin
      mem_reg[idx_reg] <= b_val;
      mem_reg[idx_inc] <= a_val;
    end
  end

  assign cmp_err = err_reg;

endmodule
